// File: rtl/out_ctl_if.sv
// Output beat stream of the GEMM output controller: one signed beat per
// valid/ready handshake, with a last flag on the final lane of a kernel.
interface out_ctl_if #(
   parameter int OUT_W = 16
) ();
   logic             m_valid;
   logic             m_ready;
   logic [OUT_W-1:0] m_data;
   logic             m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/out_ctl.sv
// out_ctl: consumer end of the ex_ctl out_busy/outr handshake. Captures NO
// accumulator lanes per kernel into a two-slot ping-pong buffer and streams
// them one lane per beat, shifted, optionally ReLU'd and saturated.

// Protocol checker for the ex_ctl side of out_ctl.
module out_ctl_chk (
   input logic       clk,
   input logic       rst,
   input logic       k_init,
   input logic       k_fin,
   input logic       out_busy,
   input logic [1:0] inflight,
   input logic       occ_wp,
   input logic [1:0] credit,
   input logic       last_hs
);
   a_init_busy : assert property (@(posedge clk) disable iff (!rst) !(k_init && out_busy));
   a_fin_idle  : assert property (@(posedge clk) disable iff (!rst) !(k_fin && (inflight == 2'd0)));
   a_fin_occ   : assert property (@(posedge clk) disable iff (!rst) !(k_fin && occ_wp));
   a_credit_ovf: assert property (@(posedge clk) disable iff (!rst)
                                  !(last_hs && !k_init && (credit == 2'd2)));
endmodule

module out_ctl #(
   parameter int NO    = 4,
   parameter int ACC_W = 32,
   parameter int OUT_W = 16,
   parameter int SHIFT = 4,
   parameter int RELU  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                k_init,
   input  logic                k_fin,
   input  logic [NO*ACC_W-1:0] acc_data,
   output logic                out_busy,
   output logic                outr,
   out_ctl_if.master           m_if
);
   localparam int BC_W = $clog2(NO);
   localparam logic [BC_W-1:0] LAST_BC = BC_W'(NO - 1);
   localparam logic [BC_W-1:0] ONE_BC  = BC_W'(1);
   localparam logic [BC_W-1:0] ZERO_BC = BC_W'(0);
   localparam logic signed [ACC_W-1:0] MAX_V    = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V    = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] ZERO_ACC = {ACC_W{1'b0}};

   logic [NO*ACC_W-1:0] slot_r [2];
   logic [1:0]          occ_r;
   logic                wp_r;
   logic                rp_r;
   logic [BC_W-1:0]     bc_r;
   logic [1:0]          credit_r;
   logic [1:0]          inflight_r;
   logic                out_busy_r;
   logic                outr_r;

   logic [1:0]          occ_nxt_s;
   logic [1:0]          credit_nxt_s;
   logic [1:0]          inflight_nxt_s;
   logic                valid_s;
   logic                hs_s;
   logic                last_hs_s;
   logic [ACC_W-1:0]    lane_s;

   // Shift (floor), optional ReLU, then clamp into the signed output range.
   function automatic logic [OUT_W-1:0] scale_lane(input logic [ACC_W-1:0] lane);
      logic signed [ACC_W-1:0] shifted;
      logic signed [ACC_W-1:0] clipped;
      shifted = $signed(lane) >>> SHIFT;
      if ((RELU != 32'sd0) && shifted[ACC_W-1]) begin
         clipped = ZERO_ACC;
      end else if (shifted > MAX_V) begin
         clipped = MAX_V;
      end else if (shifted < MIN_V) begin
         clipped = MIN_V;
      end else begin
         clipped = shifted;
      end
      return clipped[OUT_W-1:0];
   endfunction

   assign valid_s      = occ_r[rp_r];
   assign m_if.m_valid = valid_s;
   assign out_busy     = out_busy_r;
   assign outr         = outr_r;

   // Next-state for handshake, credits, in-flight count and slot occupancy.
   always_comb begin
      hs_s      = valid_s & m_if.m_ready;
      last_hs_s = hs_s & (bc_r == LAST_BC);

      credit_nxt_s = credit_r;
      case ({k_init, last_hs_s})
         2'b10:   credit_nxt_s = credit_r - 2'd1;
         2'b01:   credit_nxt_s = credit_r + 2'd1;
         default: credit_nxt_s = credit_r;
      endcase

      inflight_nxt_s = inflight_r;
      case ({k_init, k_fin})
         2'b10:   inflight_nxt_s = inflight_r + 2'd1;
         2'b01:   inflight_nxt_s = inflight_r - 2'd1;
         default: inflight_nxt_s = inflight_r;
      endcase

      // A drain and a capture always address different slots.
      occ_nxt_s = occ_r;
      if (last_hs_s) begin
         occ_nxt_s[rp_r] = 1'b0;
      end else begin
         occ_nxt_s[rp_r] = occ_r[rp_r];
      end
      if (k_fin) begin
         occ_nxt_s[wp_r] = 1'b1;
      end else begin
         occ_nxt_s[wp_r] = occ_nxt_s[wp_r];
      end
   end

   // Current beat: lane bc of the read slot, scaled; zeroed when idle.
   always_comb begin
      lane_s = slot_r[rp_r][int'(bc_r)*ACC_W +: ACC_W];
      if (valid_s) begin
         m_if.m_data = scale_lane(lane_s);
         m_if.m_last = (bc_r == LAST_BC);
      end else begin
         m_if.m_data = {OUT_W{1'b0}};
         m_if.m_last = 1'b0;
      end
   end

   // Control state plus registered out_busy/outr derived from next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_r      <= 2'b00;
         wp_r       <= 1'b0;
         rp_r       <= 1'b0;
         bc_r       <= ZERO_BC;
         credit_r   <= 2'd2;
         inflight_r <= 2'd0;
         out_busy_r <= 1'b0;
         outr_r     <= 1'b0;
      end else begin
         occ_r      <= occ_nxt_s;
         credit_r   <= credit_nxt_s;
         inflight_r <= inflight_nxt_s;
         out_busy_r <= (credit_nxt_s == 2'd0);
         outr_r     <= (occ_nxt_s != 2'b00) | (inflight_nxt_s != 2'd0);
         if (k_fin) begin
            wp_r <= ~wp_r;
         end else begin
            wp_r <= wp_r;
         end
         if (last_hs_s) begin
            bc_r <= ZERO_BC;
            rp_r <= ~rp_r;
         end else if (hs_s) begin
            bc_r <= bc_r + ONE_BC;
            rp_r <= rp_r;
         end else begin
            bc_r <= bc_r;
            rp_r <= rp_r;
         end
      end
   end

   // Ping-pong capture of the accumulator lanes on kernel completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_r[0] <= {(NO*ACC_W){1'b0}};
         slot_r[1] <= {(NO*ACC_W){1'b0}};
      end else if (k_fin) begin
         slot_r[wp_r] <= acc_data;
      end else begin
         slot_r[wp_r] <= slot_r[wp_r];
      end
   end

   out_ctl_chk u_chk (
      .clk      (clk),
      .rst      (rst),
      .k_init   (k_init),
      .k_fin    (k_fin),
      .out_busy (out_busy_r),
      .inflight (inflight_r),
      .occ_wp   (occ_r[wp_r]),
      .credit   (credit_r),
      .last_hs  (last_hs_s)
   );
endmodule

// File: tb/tb_out_ctl.sv
// Bench for out_ctl: two instances (RELU=0 and RELU=1) share one stimulus
// stream; a queue-based model of buffered lanes and credit/in-flight counts
// predicts every output on every falling edge.
module tb_out_ctl;
   localparam int NO    = 4;
   localparam int ACC_W = 32;
   localparam int OUT_W = 16;
   localparam int SHIFT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic k_init = 1'b0;
   logic k_fin = 1'b0;
   logic m_ready = 1'b0;
   logic [NO*ACC_W-1:0] acc_data = '0;
   logic busy0, outr0, busy1, outr1;

   out_ctl_if #(.OUT_W(OUT_W)) if0 ();
   out_ctl_if #(.OUT_W(OUT_W)) if1 ();
   assign if0.m_ready = m_ready;
   assign if1.m_ready = m_ready;

   out_ctl #(.NO(NO), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(0)) dut0 (
      .clk(clk), .rst(rst), .k_init(k_init), .k_fin(k_fin), .acc_data(acc_data),
      .out_busy(busy0), .outr(outr0), .m_if(if0));
   out_ctl #(.NO(NO), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(1)) dut1 (
      .clk(clk), .rst(rst), .k_init(k_init), .k_fin(k_fin), .acc_data(acc_data),
      .out_busy(busy1), .outr(outr1), .m_if(if1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: lanes waiting to be output, in order, plus counters.
   logic [ACC_W-1:0] q[$];
   int credit_m = 2;
   int inflight_m = 0;
   int pop_cnt = 0;

   function automatic logic [OUT_W-1:0] ref_val(input logic [ACC_W-1:0] lane, input bit relu);
      longint v, d, t, hi, lo;
      v  = longint'($signed(lane));
      d  = longint'(1) << SHIFT;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -hi - 1;
      if (v >= 0) t = v / d;
      else t = -((-v + d - 1) / d);
      if (relu && t < 0) t = 0;
      if (t > hi) t = hi;
      if (t < lo) t = lo;
      return t[OUT_W-1:0];
   endfunction

   function automatic logic [NO*ACC_W-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [31:0] c, input logic [31:0] d);
      return {d, c, b, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      credit_m = 2;
      inflight_m = 0;
      pop_cnt = 0;
   endtask

   task automatic model_step();
      if (rst) begin
         if (q.size() > 0 && m_ready) begin
            void'(q.pop_front());
            if (pop_cnt % NO == NO - 1) credit_m++;
            pop_cnt++;
         end
         if (k_init) begin
            credit_m--;
            inflight_m++;
         end
         if (k_fin) begin
            inflight_m--;
            for (int i = 0; i < NO; i++) q.push_back(acc_data[i*ACC_W +: ACC_W]);
         end
      end
   endtask

   task automatic compare();
      logic v, l;
      logic [OUT_W-1:0] d0, d1;
      v  = (q.size() > 0);
      d0 = v ? ref_val(q[0], 1'b0) : '0;
      d1 = v ? ref_val(q[0], 1'b1) : '0;
      l  = v && (pop_cnt % NO == NO - 1);
      chk("m_valid",      if0.m_valid, v);
      chk("m_data",       if0.m_data,  d0);
      chk("m_last",       if0.m_last,  l);
      chk("out_busy",     busy0, credit_m == 0);
      chk("outr",         outr0, v || inflight_m != 0);
      chk("relu_m_valid", if1.m_valid, v);
      chk("relu_m_data",  if1.m_data,  d1);
      chk("relu_m_last",  if1.m_last,  l);
      chk("relu_out_busy", busy1, credit_m == 0);
      chk("relu_outr",    outr1, v || inflight_m != 0);
   endtask

   always @(negedge clk) compare();

   task automatic cyc(input bit ki, input bit kf, input bit mr, input logic [NO*ACC_W-1:0] ad);
      k_init = ki;
      k_fin = kf;
      m_ready = mr;
      acc_data = ad;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},   busy0, 0);
      chk({tag, "_outr"},   outr0, 0);
      chk({tag, "_valid"},  if0.m_valid, 0);
      chk({tag, "_data"},   if0.m_data, 0);
      chk({tag, "_last"},   if0.m_last, 0);
      chk({tag, "_valid1"}, if1.m_valid, 0);
      chk({tag, "_outr1"},  outr1, 0);
   endtask

   function automatic logic [ACC_W-1:0] rand_lane();
      logic [ACC_W-1:0] edges [8];
      edges = '{32'h0007_FFF0, 32'h0007_FFFF, 32'h0008_0000, 32'hFFF8_0000,
                32'hFFF7_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
      case ($urandom_range(0, 3))
         0: return $urandom;
         1: return ACC_W'($urandom_range(0, 32'h000F_FFFF));
         2: return edges[$urandom_range(0, 7)];
         default: return -ACC_W'($urandom_range(0, 40));
      endcase
   endfunction

   logic [OUT_W-1:0] exp0 [4];
   logic [OUT_W-1:0] exp1 [4];
   logic [NO*ACC_W-1:0] zero_v;

   initial begin
      zero_v = '0;
      model_reset();
      exp0 = '{16'h0010, 16'h7FFF, 16'h8000, 16'hFFFF};
      exp1 = '{16'h0010, 16'h7FFF, 16'h0000, 16'h0000};

      // Reset held three cycles
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0, zero_v);
         chk_zero("rst_during");
      end
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, zero_v);
      chk_zero("rst_after");

      // Single kernel, spec lanes
      cyc(1'b1, 1'b0, 1'b1, zero_v);
      chk("single_busy", busy0, 0);
      chk("single_outr", outr0, 1);
      cyc(1'b0, 1'b1, 1'b1, pack4(32'h0000_0100, 32'h007F_FFF0, 32'hFFF0_0000, 32'hFFFF_FFF8));
      for (int i = 0; i < 4; i++) begin
         chk("single_valid", if0.m_valid, 1);
         chk("single_data", if0.m_data, exp0[i]);
         chk("single_relu_data", if1.m_data, exp1[i]);
         chk("single_last", if0.m_last, (i == 3));
         cyc(1'b0, 1'b0, 1'b1, zero_v);
      end
      chk("single_outr_fall", outr0, 0);
      chk("single_valid_end", if0.m_valid, 0);

      // Backpressure on beat 2
      cyc(1'b1, 1'b0, 1'b1, zero_v);
      cyc(1'b0, 1'b1, 1'b1, pack4(32'h0000_0230, 32'h0000_1230, 32'hFFFF_FF00, 32'h0000_0000));
      cyc(1'b0, 1'b0, 1'b1, zero_v);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b0, zero_v);
         chk("bp_data", if0.m_data, 16'h0123);
         chk("bp_last", if0.m_last, 0);
         chk("bp_valid", if0.m_valid, 1);
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, zero_v);

      // Throttle: two kernels with no drain
      cyc(1'b1, 1'b0, 1'b0, zero_v);
      cyc(1'b0, 1'b1, 1'b0, pack4(32'h10, 32'h20, 32'h30, 32'h40));
      cyc(1'b1, 1'b0, 1'b0, zero_v);
      chk("thr_busy_set", busy0, 1);
      cyc(1'b0, 1'b1, 1'b0, pack4(32'h50, 32'h60, 32'h70, 32'h80));
      chk("thr_busy_hold", busy0, 1);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0, 1'b1, zero_v);
         if (i < 3) chk("thr_busy_drain", busy0, 1);
         else chk("thr_busy_free", busy0, 0);
      end
      chk("thr_outr_end", outr0, 0);

      // k_init together with a last-beat handshake at credit 1
      cyc(1'b1, 1'b0, 1'b1, zero_v);
      cyc(1'b0, 1'b1, 1'b1, pack4(32'h11, 32'h22, 32'h33, 32'h44));
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, zero_v);
      cyc(1'b1, 1'b0, 1'b1, zero_v);
      chk("simul_busy", busy0, 0);
      chk("simul_outr", outr0, 1);
      cyc(1'b0, 1'b1, 1'b1, pack4(32'h55, 32'h66, 32'h77, 32'h88));
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, zero_v);

      // Reset mid-stream after beat 2
      cyc(1'b1, 1'b0, 1'b1, zero_v);
      cyc(1'b0, 1'b1, 1'b1, pack4(32'h100, 32'h200, 32'h300, 32'h400));
      cyc(1'b0, 1'b0, 1'b1, zero_v);
      cyc(1'b0, 1'b0, 1'b1, zero_v);
      rst = 1'b0;
      model_reset();
      #1;
      chk_zero("mid_rst");
      cyc(1'b0, 1'b0, 1'b1, zero_v);
      cyc(1'b0, 1'b0, 1'b1, zero_v);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b1, zero_v);
      cyc(1'b0, 1'b1, 1'b1, pack4(32'hFFFF_FFE0, 32'h50, 32'h0, 32'h1));
      chk("mid_rst_lane0", if0.m_data, 16'hFFFE);
      chk("mid_rst_lane0_relu", if1.m_data, 16'h0000);
      chk("mid_rst_last", if0.m_last, 0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, zero_v);

      // Randomized traffic within the credit protocol
      for (int n = 0; n < 3000; n++) begin
         bit ki, kf, mr;
         logic [NO*ACC_W-1:0] ad;
         mr = ($urandom_range(0, 99) < 65);
         ki = (credit_m > 0) && ($urandom_range(0, 99) < 40);
         kf = (inflight_m > 0) && ($urandom_range(0, 99) < 40);
         for (int i = 0; i < NO; i++) ad[i*ACC_W +: ACC_W] = rand_lane();
         cyc(ki, kf, mr, ad);
      end

      // Drain everything still in flight
      for (int i = 0; i < 3; i++) cyc(1'b0, (inflight_m > 0), 1'b1, zero_v);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, zero_v);
      chk("final_outr", outr0, 0);
      chk("final_busy", busy0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
